// File: rtl/adc_deserializer_pkg.sv
// Shared types and sizes for the serial ADC deserializer.
// Imported by the lane shifter and the top-level framer.
package adc_pkg;

  localparam int NUM_CH   = 8;
  localparam int WORD_W   = 16;
  localparam int BITCNT_W = 4;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/adc_deserializer_chan_shift.sv
// One serial lane: WORD_W-bit shift register with realign load.
// word is the register value after this cycle's shift.
module chan_shift
  import adc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear_load,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] sh_q;
  logic [WORD_W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (shift_en) begin
      if (MSB_FIRST) begin
        if (clear_load) sh_d = {{(WORD_W-1){1'b0}}, bit_in};
        else            sh_d = {sh_q[WORD_W-2:0], bit_in};
      end else begin
        if (clear_load) sh_d = {bit_in, {(WORD_W-1){1'b0}}};
        else            sh_d = {bit_in, sh_q[WORD_W-1:1]};
      end
    end
  end

  assign word = sh_d;

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

endmodule

// File: rtl/adc_deserializer.sv
// Frame-aligned deserializer for NUM_CH serial ADC lanes.
// Publishes a word set with a one-cycle frame_valid strobe.
module adc_deserializer
  import adc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                ext_clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
  input  logic [NUM_CH-1:0]   sdata,
  output logic [WORD_W-1:0]   par [NUM_CH-1:0],
  output logic                frame_valid,
  output logic [BITCNT_W-1:0] bit_cnt,
  output logic [15:0]         frame_cnt,
  output logic                locked,
  output logic                sync_err
);

  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(WORD_W - 1);

  state_e              state_q, state_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                sync_err_q, sync_err_d;
  logic                frame_valid_q, frame_valid_d;
  logic [WORD_W-1:0]   par_q [NUM_CH-1:0];
  logic [WORD_W-1:0]   par_d [NUM_CH-1:0];
  logic [WORD_W-1:0]   word [NUM_CH-1:0];
  logic                shift_en;
  logic                clear_load;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    chan_shift #(
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk        (ext_clk),
      .rst        (rst),
      .shift_en   (shift_en),
      .clear_load (clear_load),
      .bit_in     (sdata[g]),
      .word       (word[g])
    );
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    sync_err_d    = sync_err_q;
    frame_valid_d = 1'b0;
    par_d         = par_q;
    shift_en      = 1'b0;
    clear_load    = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (sync) begin
            shift_en   = 1'b1;
            clear_load = 1'b1;
            bit_cnt_d  = BITCNT_W'(1);
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          // late sync: drop the partial word and restart on this bit
          if (sync && bit_cnt_q != '0) begin
            clear_load = 1'b1;
            bit_cnt_d  = BITCNT_W'(1);
            sync_err_d = 1'b1;
          end else if (bit_cnt_q == LAST_BIT) begin
            for (int i = 0; i < NUM_CH; i++) par_d[i] = word[i];
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            bit_cnt_d     = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ext_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      sync_err_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      par_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      sync_err_q    <= sync_err_d;
      frame_valid_q <= frame_valid_d;
      par_q         <= par_d;
    end
  end

  assign par         = par_q;
  assign frame_valid = frame_valid_q;
  assign bit_cnt     = bit_cnt_q;
  assign frame_cnt   = frame_cnt_q;
  assign locked      = (state_q == SHIFT);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_adc_deserializer.sv
// Bench for adc_deserializer: MSB- and LSB-first instances share stimulus
// and are checked every cycle against a bit-queue frame model.
module tb_adc_deserializer;
  import adc_pkg::*;

  typedef logic [15:0] wset_t [8];

  logic       ext_clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] sdata = '0;

  logic [15:0] par_m [7:0];
  logic [15:0] par_l [7:0];
  logic        fv_m, fv_l, lk_m, lk_l, se_m, se_l;
  logic [3:0]  bc_m, bc_l;
  logic [15:0] fc_m, fc_l;

  adc_deserializer #(.MSB_FIRST(1'b1)) dut_m (
    .ext_clk (ext_clk), .rst (rst), .en (en), .sync (sync),
    .sdata (sdata), .par (par_m), .frame_valid (fv_m),
    .bit_cnt (bc_m), .frame_cnt (fc_m), .locked (lk_m),
    .sync_err (se_m)
  );

  adc_deserializer #(.MSB_FIRST(1'b0)) dut_l (
    .ext_clk (ext_clk), .rst (rst), .en (en), .sync (sync),
    .sdata (sdata), .par (par_l), .frame_valid (fv_l),
    .bit_cnt (bc_l), .frame_cnt (fc_l), .locked (lk_l),
    .sync_err (se_l)
  );

  always #5 ext_clk = ~ext_clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  bit          m_locked = 0;
  int          m_pos = 0;
  logic [15:0] m_frames = '0;
  bit          m_err = 0;
  bit          m_fv = 0;
  logic [15:0] m_par_msb [8];
  logic [15:0] m_par_lsb [8];
  bit          m_bits [8][$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_fv = 0;
    if (rst) begin
      m_locked = 0; m_pos = 0; m_frames = '0; m_err = 0;
      for (int i = 0; i < 8; i++) begin
        m_par_msb[i] = '0; m_par_lsb[i] = '0; m_bits[i].delete();
      end
    end else if (en) begin
      if ((!m_locked && sync) || (m_locked && sync && m_pos != 0)) begin
        if (m_locked) m_err = 1;
        m_locked = 1;
        for (int i = 0; i < 8; i++) begin
          m_bits[i].delete();
          m_bits[i].push_back(sdata[i]);
        end
        m_pos = 1;
      end else if (m_locked) begin
        for (int i = 0; i < 8; i++) m_bits[i].push_back(sdata[i]);
        m_pos++;
        if (m_pos == 16) begin
          for (int i = 0; i < 8; i++) begin
            m_par_msb[i] = '0; m_par_lsb[i] = '0;
            for (int k = 0; k < 16; k++) begin
              m_par_msb[i][15-k] = m_bits[i][k];
              m_par_lsb[i][k]    = m_bits[i][k];
            end
            m_bits[i].delete();
          end
          m_fv = 1;
          m_frames = m_frames + 16'd1;
          m_pos = 0;
        end
      end
    end
  endtask

  always @(negedge ext_clk) begin
    if (chk_on) begin
      chk("fv_m", {31'd0, fv_m}, {31'd0, m_fv});
      chk("fv_l", {31'd0, fv_l}, {31'd0, m_fv});
      chk("bc_m", {28'd0, bc_m}, 32'(m_pos));
      chk("bc_l", {28'd0, bc_l}, 32'(m_pos));
      chk("fc_m", {16'd0, fc_m}, {16'd0, m_frames});
      chk("fc_l", {16'd0, fc_l}, {16'd0, m_frames});
      chk("lk_m", {31'd0, lk_m}, {31'd0, m_locked});
      chk("lk_l", {31'd0, lk_l}, {31'd0, m_locked});
      chk("se_m", {31'd0, se_m}, {31'd0, m_err});
      chk("se_l", {31'd0, se_l}, {31'd0, m_err});
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("par_m[%0d]", i), {16'd0, par_m[i]},
            {16'd0, m_par_msb[i]});
        chk($sformatf("par_l[%0d]", i), {16'd0, par_l[i]},
            {16'd0, m_par_lsb[i]});
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic s,
                     input logic [7:0] d);
    rst = r; en = e; sync = s; sdata = d;
    @(posedge ext_clk);
    model_step();
    @(negedge ext_clk);
  endtask

  task automatic send_bits(input wset_t w, input bit do_sync,
                           input int k0, input int k1);
    logic [7:0] d;
    for (int k = k0; k < k1; k++) begin
      for (int i = 0; i < 8; i++) d[i] = w[i][15-k];
      cyc(1'b0, 1'b1, do_sync && (k == k0), d);
    end
  endtask

  function automatic wset_t mk(input logic [15:0] base);
    wset_t w;
    for (int i = 0; i < 8; i++) w[i] = base ^ (16'h0101 * 16'(i));
    return w;
  endfunction

  wset_t w;

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk_on = 1;
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 1'b0, 8'hFF);

    // 1: first aligned frame
    w = '{default: 16'h0000};
    w[0] = 16'hA5C3; w[7] = 16'h0001;
    send_bits(w, 1'b1, 0, 16);
    chk("t1_fv", {31'd0, fv_m}, 32'd1);
    chk("t1_par0", {16'd0, par_m[0]}, 32'h0000A5C3);
    chk("t1_par7", {16'd0, par_m[7]}, 32'h00000001);
    chk("t1_fc", {16'd0, fc_m}, 32'd1);
    chk("t1_lk", {31'd0, lk_m}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t1_fv_one", {31'd0, fv_m}, 32'd0);

    // 2: three free-running words after one sync
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    send_bits(mk(16'h1234), 1'b1, 0, 16);
    chk("t2_w0", {16'd0, par_m[0]}, 32'h00001234);
    send_bits(mk(16'hFFFF), 1'b0, 0, 16);
    chk("t2_w1", {16'd0, par_m[3]}, 32'h0000FCFC);
    send_bits(mk(16'h0000), 1'b0, 0, 16);
    chk("t2_w2", {16'd0, par_m[1]}, 32'h00000101);
    chk("t2_fc", {16'd0, fc_m}, 32'd3);
    chk("t2_se", {31'd0, se_m}, 32'd0);

    // 3: late sync at bit 7
    send_bits(mk(16'h5A5A), 1'b0, 0, 7);
    chk("t3_bc", {28'd0, bc_m}, 32'd7);
    send_bits(mk(16'hBEEF), 1'b1, 0, 16);
    chk("t3_se", {31'd0, se_m}, 32'd1);
    chk("t3_par", {16'd0, par_m[0]}, 32'h0000BEEF);
    chk("t3_fc", {16'd0, fc_m}, 32'd4);
    send_bits(mk(16'h0F0F), 1'b0, 0, 16);
    chk("t3_sticky", {31'd0, se_m}, 32'd1);

    // 4: pause at bit 9
    send_bits(mk(16'hC0DE), 1'b0, 0, 9);
    for (int c = 0; c < 5; c++) cyc(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("t4_bc", {28'd0, bc_m}, 32'd9);
    chk("t4_par", {16'd0, par_m[0]}, 32'h00000F0F);
    send_bits(mk(16'hC0DE), 1'b0, 9, 16);
    chk("t4_fv", {31'd0, fv_m}, 32'd1);
    chk("t4_word", {16'd0, par_m[0]}, 32'h0000C0DE);

    // 5: reset mid-word
    send_bits(mk(16'h7777), 1'b0, 0, 12);
    chk("t5_bc12", {28'd0, bc_m}, 32'd12);
    cyc(1'b1, 1'b1, 1'b0, 8'hFF);
    chk("t5_par", {16'd0, par_m[0]}, 32'd0);
    chk("t5_bc", {28'd0, bc_m}, 32'd0);
    chk("t5_lk", {31'd0, lk_m}, 32'd0);
    chk("t5_fc", {16'd0, fc_m}, 32'd0);
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 1'b0, 8'hAA);
    chk("t5_idle", {28'd0, bc_m}, 32'd0);

    // 6: LSB-first ordering, then frame counter wrap
    w = '{default: 16'h8000};
    send_bits(w, 1'b1, 0, 16);
    chk("t6_lsb0", {16'd0, par_l[0]}, 32'h00000001);
    chk("t6_lsb5", {16'd0, par_l[5]}, 32'h00000001);
    chk("t6_msb0", {16'd0, par_m[0]}, 32'h00008000);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    dut_m.frame_cnt_q = 16'hFFFF;
    dut_l.frame_cnt_q = 16'hFFFF;
    m_frames = 16'hFFFF;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t6_pre", {16'd0, fc_m}, 32'h0000FFFF);
    send_bits(mk(16'h1357), 1'b0, 0, 16);
    chk("t6_wrap_m", {16'd0, fc_m}, 32'd0);
    chk("t6_wrap_l", {16'd0, fc_l}, 32'd0);
    chk("t6_fv", {31'd0, fv_l}, 32'd1);

    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adc_deserializer.md
Name: adc_deserializer

Overview:
Upstream stage of the FIFO loader. Converts NUM_CH parallel serial ADC data lines (one bit per clock per channel, 16-bit words) into a bank of parallel words `par`. It aligns to a frame-sync pulse, publishes a complete word set with a one-cycle frame_valid strobe, and flags misaligned sync pulses. All logic runs in the ext_clk domain; the loader consumes `par` and `bit_cnt`.

Parameters:
NUM_CH, 8, number of serial data lanes / output words
WORD_W, 16, bits per word (bit counter width = clog2(WORD_W) = 4)
MSB_FIRST, 1, 1 = first serial bit is word MSB; 0 = first bit is LSB

Ports:
ext_clk  input  1  sole clock; all sampling on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  shift enable; low = pause (hold all state)
sync  input  1  frame-start pulse, high during the cycle carrying bit 0 of every lane
sdata  input  NUM_CH  serial data; sdata[i] feeds channel i
par  output  NUM_CH x WORD_W  unpacked array par[NUM_CH-1:0], each WORD_W bits; last completed word per channel
frame_valid  output  1  one-cycle strobe: par updated this cycle
bit_cnt  output  4  current bit position 0..WORD_W-1 (0 in IDLE)
frame_cnt  output  16  completed frames since reset, wraps
locked  output  1  high in SHIFT state
sync_err  output  1  sticky: sync seen at bit_cnt != 0 while locked

Behaviour:
- Reset (rst=1 at edge): state=IDLE; par all 0; shift regs 0; bit_cnt=0; frame_cnt=0; frame_valid=0; locked=0; sync_err=0. Applies mid-word too: the partial word is discarded and par is zeroed.
- en=0: no state, counter, or shift-reg change; frame_valid=0; lock retained.
- IDLE: ignore sdata.
  - en&sync: shift in bit 0, bit_cnt<=1, go to SHIFT.
- SHIFT, en=1, each cycle: shift sdata[i] into channel i.
  - MSB_FIRST=1: sh<={sh[W-2:0],sdata[i]}.
  - MSB_FIRST=0: sh<={sdata[i],sh[W-1:1]}.
  - bit_cnt increments.
- End of word (bit_cnt==WORD_W-1, en=1):
  - par[i] <= completed word including the current bit.
  - frame_valid<=1; frame_cnt+=1 (0xFFFF wraps to 0).
  - bit_cnt wraps to 0.
  - Stay in SHIFT: free-running, sync not required each word.
- Latency: last bit sampled at edge N; par and frame_valid are visible after edge N and valid for exactly one cycle. par holds until the next frame.
- sync while SHIFT at bit_cnt==0: normal, no effect beyond the shift.
- sync while SHIFT at bit_cnt!=0:
  - sync_err<=1 (sticky until rst).
  - Partial word discarded: shift regs take only the current bit.
  - bit_cnt<=1.
  - No frame_valid, par unchanged.
- sync and end of word in the same cycle: sync only coincides with bit_cnt==0, so this is the misalignment case above.
- locked = (state==SHIFT). Exits only via rst.

Decomposition:
- Package adc_pkg: NUM_CH, WORD_W, BITCNT_W=4, state enum {IDLE, SHIFT}.
- Sub-module chan_shift: one lane's WORD_W shift register, with inputs shift_en, clear_load (realign), bit_in, MSB_FIRST, and output word. Instantiate it NUM_CH times in a generate loop.
- The top level holds the FSM, bit_cnt, frame_cnt, sync_err, and the par registers.

Test Plan:
1. Reset then sync with lane0 serial 0xA5C3 (MSB first), lane7 0x0001, other lanes 0 → 16 cycles later: frame_valid=1 for one cycle; par[0]=0xA5C3, par[7]=0x0001; frame_cnt=1; locked=1.
2. Three back-to-back words 0x1234, 0xFFFF, 0x0000 with a single initial sync → frame_valid every 16 cycles exactly; par sequence matches; sync_err=0; frame_cnt=3.
3. Sync re-asserted at bit_cnt=7 → sync_err=1 and stays set; no frame_valid for the broken word; next frame_valid 16 cycles after the late sync, with the correct word.
4. en low for 5 cycles mid-word (bit_cnt=9) → bit_cnt holds at 9; frame_valid delayed by 5 cycles; par word unchanged by the pause.
5. rst at bit_cnt=12 → next cycle par=0, bit_cnt=0, locked=0, frame_cnt=0; sdata ignored until a new sync.
6. MSB_FIRST=0 with bits 1,0,0,...,0 → par[i]=0x0001. frame_cnt wrap: preload 65535 frames, and one more frame gives frame_cnt=0.
